// File: rtl/gauss_pkg.sv
// gauss_pkg: kernel, normalisation constants and FSM state codes for the 5x5 Gaussian filter.
package gauss_pkg;
    localparam int KSUM = 159;
    localparam int NORM_RECIP = 412;
    localparam int NORM_SHIFT = 16;
    localparam logic [3:0] KERNEL [5][5] = '{
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd5, 4'd12, 4'd15, 4'd12, 4'd5},
        '{4'd4, 4'd9,  4'd12, 4'd9,  4'd4},
        '{4'd2, 4'd4,  4'd5,  4'd4,  4'd2}
    };
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FILL  = 3'd1;
    localparam logic [2:0] RUN   = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
endpackage

// File: rtl/gauss_line_buffer.sv
// gauss_line_buffer: four-row pixel store addressed by the shared write column.
// taps[i] is the pixel at the current column from row r-1-i; rows shift down on each write.
module gauss_line_buffer #(
    parameter int IMG_W = 32,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(IMG_W)-1:0]   col,
    input  logic [PIX_W-1:0]           din,
    output logic [4*PIX_W-1:0]         taps
);
    logic [PIX_W-1:0] mem [4][IMG_W];

    for (genvar i = 0; i < 4; i++) begin : g_tap
        assign taps[i*PIX_W +: PIX_W] = mem[i][col];
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[0][col] <= din;
            for (int i = 1; i < 4; i++) mem[i][col] <= mem[i-1][col];
        end
    end
endmodule

// File: rtl/gauss5x5_stream_filter.sv
// gauss5x5_stream_filter: streaming 5x5 Gaussian smoothing (Canny stage 1), 3-stage pipe.
// Define GAUSS_ROUND_EN for round-half-up normalisation; default truncates.
module gauss5x5_stream_filter
    import gauss_pkg::*;
#(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int PIX_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PIX_W-1:0]           in_pixel,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PIX_W-1:0]           out_pixel,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam int SW = PIX_W + 8;
    localparam int PW = PIX_W + 17;
`ifdef GAUSS_ROUND_EN
    localparam logic [PW-1:0] RND = PW'(1) << (NORM_SHIFT - 1);
`else
    localparam logic [PW-1:0] RND = '0;
`endif

    logic [2:0]         state;
    logic [RW-1:0]      row, r1, r2;
    logic [CW-1:0]      col, c1, c2;
    logic [PIX_W-1:0]   win [5][5];
    logic [4*PIX_W-1:0] taps;
    logic [SW-1:0]      rsum [5];
    logic [SW-1:0]      rs [5];
    logic [SW-1:0]      total;
    logic [PW-1:0]      prod, q;
    logic               v1, v2, stall, xfer, last_col, last_px, win_ok;

    assign stall      = out_valid && !out_ready;
    assign in_ready   = (state == FILL || state == RUN) && !stall;
    assign xfer       = in_valid && in_ready;
    assign last_col   = col == CW'(IMG_W - 1);
    assign last_px    = last_col && row == RW'(IMG_H - 1);
    assign win_ok     = row >= RW'(4) && col >= CW'(4);
    assign busy       = state != IDLE;
    assign frame_done = state == DONE;

    gauss_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
        .clk(clk), .we(xfer), .col(col), .din(in_pixel), .taps(taps)
    );

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rsum[i] = '0;
            for (int j = 0; j < 5; j++) rsum[i] = rsum[i] + SW'(KERNEL[i][j]) * SW'(win[i][j]);
        end
        total = rs[0] + rs[1] + rs[2] + rs[3] + rs[4];
        prod  = PW'(total) * PW'(NORM_RECIP) + RND;
        q     = prod >> NORM_SHIFT;
    end

    // Window row 0 is the oldest line (r-4); the newest column enters at index 4.
    always_ff @(posedge clk) begin
        if (xfer) begin
            for (int i = 0; i < 5; i++) for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
            for (int i = 0; i < 4; i++) win[i][4] <= taps[(3-i)*PIX_W +: PIX_W];
            win[4][4] <= in_pixel;
            r1 <= row - RW'(2);
            c1 <= col - CW'(2);
        end
        if (!stall) begin
            rs <= rsum;
            r2 <= r1;
            c2 <= c1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            if (state == IDLE && start) begin
                state <= FILL;
                row   <= '0;
                col   <= '0;
            end
            if (xfer) begin
                col <= last_col ? '0 : col + 1'b1;
                row <= last_col ? row + 1'b1 : row;
                if (last_px) state <= FLUSH;
                else if (state == FILL && row == RW'(4) && col == CW'(3)) state <= RUN;
            end
            if (state == FLUSH && !v1 && !v2 && (!out_valid || out_ready)) state <= DONE;
            if (state == DONE) state <= IDLE;
            // Every stage holds while the output register is blocked.
            if (!stall) begin
                v1        <= xfer && win_ok;
                v2        <= v1;
                out_valid <= v2;
                if (v2) begin
                    out_pixel <= |q[PW-1:PIX_W] ? '1 : q[PIX_W-1:0];
                    out_row   <= r2;
                    out_col   <= c2;
                end
            end
        end
    end
endmodule
